inst_rom_resp: RTL and testbench
================================

// Module: inst_rom_resp
// PURPOSE
//   Responder end of the core's instruction-fetch interface (PcReg ce/pc -> inst).
//   Holds the program in a word array and returns the addressed instruction in the
//   same cycle, so If2Id latches the pc and inst pair together.
//   A byte-serial loader port fills the array before execution, making the block a
//   loadable ROM: FSM LOAD -> RUN, with byte assembly and a word counter.
// PARAMETERS
//   DEPTH_LOG2  10  log2 of word count (1024 x 32-bit words)
//   ADDR_W      32  width of fetch byte address (matches InstAddrBus)
//   DATA_W      32  instruction width (matches InstBus)
// PORTS
//   clk           in   1             system clock
//   rst           in   1             synchronous reset, active-low
//   rom_ce_i      in   1             fetch enable from PcReg
//   inst_addr_i   in   ADDR_W        fetch byte address (pc)
//   inst_o        out  DATA_W        instruction word to If2Id
//   load_start_i  in   1             restart loading from word 0
//   load_valid_i  in   1             loader byte strobe
//   load_byte_i   in   8             loader byte, little-endian within word
//   load_done_i   in   1             end of program image
//   load_ready_o  out  1             loader may present a byte
//   busy_o        out  1             1 while in LOAD
//   load_cnt_o    out  DEPTH_LOG2+1  words written since last load start
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=LOAD, word counter=0, byte index=0, assembly reg=0.
//   Array contents are not cleared.
//   Outputs in reset/LOAD: load_ready_o=1, busy_o=1, load_cnt_o=0 (after reset), inst_o=0.
// - LOAD:
//   - Each cycle with load_valid_i=1, the byte goes to lane byte_idx (0=bits[7:0]), and
//     byte_idx increments.
//   - On the 4th byte, the word is written to mem[cnt] in that clock edge; cnt++ and
//     byte_idx returns to 0.
//   - load_done_i=1: if byte_idx!=0, the partial word is written zero-padded (including
//     a byte accepted in the same cycle) and cnt++. State -> RUN next cycle.
//   - load_valid_i and load_done_i in the same cycle: the byte is accepted first, then done.
//   - cnt reaching 2**DEPTH_LOG2 forces RUN on that edge; load_ready_o=0 from then on.
//     Further bytes are ignored.
//   - load_valid_i while load_ready_o=0 is ignored.
// - RUN:
//   - load_ready_o=0, busy_o=0; load_valid_i and load_done_i are ignored.
//   - Fetch is combinational, zero latency: inst_o = mem[inst_addr_i[DEPTH_LOG2+1:2]]
//     when rom_ce_i=1.
//   - inst_o=0 when rom_ce_i=0.
//   - inst_o=0 when inst_addr_i[ADDR_W-1:DEPTH_LOG2+2]!=0 (out of range).
//   - inst_addr_i[1:0] is ignored (word-aligned fetch).
// - load_start_i=1 (any state, rst high): next cycle state=LOAD, cnt=0, byte_idx=0,
//   assembly reg cleared. It has priority over load_valid_i/load_done_i in that cycle.
// - Reset mid-load: the partial word is discarded; words already written stay in the array.
// - Array: word registers, one write port (loader), one async read port (fetch).
//   No read/write conflict is possible because fetch returns 0 in LOAD.
// - load_cnt_o holds its final value in RUN until the next load_start_i or reset.
// TESTING
// 1 Reset then load bytes 13,00,00,02 / 93,00,10,00, done -> mem[0]=0x02000013,
//   mem[1]=0x00100093, load_cnt_o=2, busy_o=0 next cycle.
// 2 RUN, ce=1, addr=0x4 -> inst_o=0x00100093 same cycle; addr=0x6 -> same word;
//   ce=0 -> inst_o=0.
// 3 Load 6 bytes AA,BB,CC,DD,11,22 + done -> mem[1]=0x00002211, cnt=2;
//   byte and done in the same cycle -> byte included.
// 4 DEPTH_LOG2=2: load 20 bytes -> RUN after the 16th byte, cnt=4, last 4 bytes ignored;
//   addr=0x10 -> inst_o=0.
// 5 Fetch ce=1 during LOAD -> inst_o=0; load_valid in RUN -> array unchanged.
// 6 rst low after 2 bytes of word 1 -> LOAD, cnt=0, mem[0] retained;
//   load_start_i in RUN -> busy_o=1 next cycle, cnt=0.

Source files
------------

// File: rtl/inst_rom_resp_if.sv
// Instruction-fetch and loader bundle for the loadable instruction ROM.
// The master is the core/loader side and the slave is the ROM responder.
interface inst_rom_resp_if #(
   parameter int DEPTH_LOG2 = 10,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
);
   logic                  rom_ce_i;
   logic [ADDR_W-1:0]     inst_addr_i;
   logic [DATA_W-1:0]     inst_o;
   logic                  load_start_i;
   logic                  load_valid_i;
   logic [7:0]            load_byte_i;
   logic                  load_done_i;
   logic                  load_ready_o;
   logic                  busy_o;
   logic [DEPTH_LOG2:0]   load_cnt_o;

   modport master (
      output rom_ce_i, inst_addr_i, load_start_i, load_valid_i, load_byte_i, load_done_i,
      input  inst_o, load_ready_o, busy_o, load_cnt_o
   );

   modport slave (
      input  rom_ce_i, inst_addr_i, load_start_i, load_valid_i, load_byte_i, load_done_i,
      output inst_o, load_ready_o, busy_o, load_cnt_o
   );
endinterface

// File: rtl/inst_rom_resp.sv
// Loadable instruction ROM: a byte-serial loader assembles little-endian words
// into a register array while in LOAD; in RUN the array answers instruction
// fetches combinationally so the pc and its instruction are latched together.
module inst_rom_resp #(
   parameter int DEPTH_LOG2 = 10,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic           clk,
   input  logic           rst,
   inst_rom_resp_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [DATA_W-1:0]      asm_q, asm_d;
   logic [DATA_W-1:0]      mem_q [DEPTH];

   logic [DATA_W-1:0]      word_s;
   logic                   pending_s;
   logic                   we_s;
   logic [DEPTH_LOG2-1:0]  waddr_s;
   logic [DATA_W-1:0]      wdata_s;
   logic [DEPTH_LOG2-1:0]  raddr_s;
   logic                   in_range_s;
   logic                   unused_addr_lsb_s;

   // Merge an incoming loader byte into its lane of the assembly word.
   always_comb begin
      word_s = asm_q;
      if (bus.load_valid_i) begin
         case (byte_idx_q)
            2'd0:    word_s[7:0]   = bus.load_byte_i;
            2'd1:    word_s[15:8]  = bus.load_byte_i;
            2'd2:    word_s[23:16] = bus.load_byte_i;
            default: word_s[31:24] = bus.load_byte_i;
         endcase
      end else begin
         word_s = asm_q;
      end
   end

   // A partial word still needs writing if, after this cycle's byte, the lane index is not back at zero.
   always_comb begin
      pending_s = 1'b0;
      if (bus.load_valid_i) begin
         pending_s = (byte_idx_q != 2'd3);
      end else begin
         pending_s = (byte_idx_q != 2'd0);
      end
   end

   // Loader FSM: next state, word counter, byte assembly and array write strobe.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      we_s       = 1'b0;
      waddr_s    = cnt_q[DEPTH_LOG2-1:0];
      wdata_s    = word_s;
      if (bus.load_start_i) begin
         state_d    = ST_LOAD;
         cnt_d      = '0;
         byte_idx_d = 2'd0;
         asm_d      = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (bus.load_valid_i) begin
                  if (byte_idx_q == 2'd3) begin
                     we_s       = 1'b1;
                     cnt_d      = cnt_q + CNT_W'(1);
                     byte_idx_d = 2'd0;
                     asm_d      = '0;
                  end else begin
                     byte_idx_d = byte_idx_q + 2'd1;
                     asm_d      = word_s;
                  end
               end else begin
                  asm_d = asm_q;
               end
               if (bus.load_done_i) begin
                  // Flush a zero-padded partial word (a same-cycle byte is already merged).
                  if (pending_s) begin
                     we_s  = 1'b1;
                     cnt_d = cnt_q + CNT_W'(1);
                  end else begin
                     we_s = we_s;
                  end
                  state_d    = ST_RUN;
                  byte_idx_d = 2'd0;
                  asm_d      = '0;
               end else begin
                  state_d = ST_LOAD;
               end
               // A full array ends loading on the edge that writes the last word.
               if (cnt_d == CNT_W'(DEPTH)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = state_d;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d    = ST_LOAD;
               cnt_d      = '0;
               byte_idx_d = 2'd0;
               asm_d      = '0;
            end
         endcase
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_LOAD;
         cnt_q      <= '0;
         byte_idx_q <= 2'd0;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
      end
   end

   // Program array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && we_s) begin
         mem_q[waddr_s] <= wdata_s;
      end
   end

   assign raddr_s           = bus.inst_addr_i[DEPTH_LOG2+1:2];
   assign in_range_s        = (bus.inst_addr_i[ADDR_W-1:DEPTH_LOG2+2] == '0);
   assign unused_addr_lsb_s = ^bus.inst_addr_i[1:0];

   // Zero-latency fetch; returns zero while loading, disabled or out of range.
   always_comb begin
      bus.inst_o = '0;
      if ((state_q == ST_RUN) && bus.rom_ce_i && in_range_s) begin
         bus.inst_o = mem_q[raddr_s];
      end else begin
         bus.inst_o = '0;
      end
   end

   assign bus.load_ready_o = (state_q == ST_LOAD);
   assign bus.busy_o       = (state_q == ST_LOAD);
   assign bus.load_cnt_o   = cnt_q;
endmodule

// File: tb/tb_inst_rom_resp.sv
// Self-checking bench for inst_rom_resp: directed table plus randomized loads
// checked against a byte-queue reference model of the loadable ROM.
module tb_inst_rom_resp;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int DL  = 10;
   localparam int DLS = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_rom_resp_if #(.DEPTH_LOG2(DL),  .ADDR_W(AW), .DATA_W(DW)) bus ();
   inst_rom_resp_if #(.DEPTH_LOG2(DLS), .ADDR_W(AW), .DATA_W(DW)) bus_s ();

   inst_rom_resp #(.DEPTH_LOG2(DL),  .ADDR_W(AW), .DATA_W(DW)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
   inst_rom_resp #(.DEPTH_LOG2(DLS), .ADDR_W(AW), .DATA_W(DW)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: accepted bytes of the current word, word count, LOAD flag, array image
   logic [7:0]  m_q [$];
   int          m_cnt;
   bit          m_load;
   logic [31:0] ref_mem [1024];

   typedef struct {
      logic        ce;
      logic [31:0] addr;
      logic [31:0] exp;
   } fvec_t;
   fvec_t tbl [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.load_start_i = 1'b0;
      bus.load_valid_i = 1'b0;
      bus.load_done_i  = 1'b0;
      bus.load_byte_i  = 8'h00;
   endtask

   task automatic m_commit();
      logic [31:0] w;
      w = 32'h0;
      foreach (m_q[i]) w[8*i +: 8] = m_q[i];
      ref_mem[m_cnt] = w;
      m_cnt++;
      m_q.delete();
      if (m_cnt == 1024) m_load = 1'b0;
   endtask

   task automatic m_accept(input logic [7:0] b);
      if (m_load) begin
         m_q.push_back(b);
         if (m_q.size() == 4) m_commit();
      end
   endtask

   task automatic m_done();
      if (m_load) begin
         if (m_q.size() != 0) m_commit();
         m_load = 1'b0;
      end
   endtask

   task automatic m_restart();
      m_load = 1'b1;
      m_cnt  = 0;
      m_q.delete();
   endtask

   // one loader cycle on the large instance
   task automatic put(input logic [7:0] b, input bit valid, input bit done, input bit start);
      bus.load_valid_i = valid;
      bus.load_byte_i  = b;
      bus.load_done_i  = done;
      bus.load_start_i = start;
      tick();
      idle_in();
      if (start) begin
         m_restart();
      end else begin
         if (valid) m_accept(b);
         if (done) m_done();
      end
   endtask

   function automatic logic [31:0] m_fetch(input logic ce, input logic [31:0] addr);
      if (m_load || !ce || (addr[31:12] != 20'h0)) return 32'h0;
      return ref_mem[addr[11:2]];
   endfunction

   task automatic fetch(input string name, input logic ce, input logic [31:0] addr, input logic [31:0] exp);
      bus.rom_ce_i    = ce;
      bus.inst_addr_i = addr;
      #1;
      chk(name, bus.inst_o, exp);
      bus.rom_ce_i = 1'b0;
   endtask

   task automatic chk_state(input string name);
      chk({name, " busy"},  bus.busy_o,       m_load);
      chk({name, " ready"}, bus.load_ready_o, m_load);
      chk({name, " cnt"},   bus.load_cnt_o,   64'(m_cnt));
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] a;
      logic [31:0] e;
      int          n;
      int          sel;

      rst = 1'b0;
      idle_in();
      bus.rom_ce_i = 1'b0;
      bus.inst_addr_i = 32'h0;
      bus_s.rom_ce_i = 1'b0;
      bus_s.inst_addr_i = 32'h0;
      bus_s.load_start_i = 1'b0;
      bus_s.load_valid_i = 1'b0;
      bus_s.load_done_i = 1'b0;
      bus_s.load_byte_i = 8'h00;
      m_restart();
      tick();
      tick();
      // reset state
      chk("rst busy",  bus.busy_o, 1'b1);
      chk("rst ready", bus.load_ready_o, 1'b1);
      chk("rst cnt",   bus.load_cnt_o, 11'd0);
      fetch("rst inst", 1'b1, 32'h0, 32'h0);
      rst = 1'b1;

      // basic two-word program
      put(8'h13, 1, 0, 0); put(8'h00, 1, 0, 0); put(8'h00, 1, 0, 0); put(8'h02, 1, 0, 0);
      put(8'h93, 1, 0, 0); put(8'h00, 1, 0, 0); put(8'h10, 1, 0, 0); put(8'h00, 1, 0, 0);
      fetch("load fetch zero", 1'b1, 32'h0, 32'h0);
      put(8'h00, 0, 1, 0);
      chk("t1 busy", bus.busy_o, 1'b0);
      chk("t1 ready", bus.load_ready_o, 1'b0);
      chk("t1 cnt", bus.load_cnt_o, 11'd2);

      // fetch table
      tbl[0] = '{1'b1, 32'h0000_0000, 32'h0200_0013};
      tbl[1] = '{1'b1, 32'h0000_0004, 32'h0010_0093};
      tbl[2] = '{1'b1, 32'h0000_0006, 32'h0010_0093};
      tbl[3] = '{1'b1, 32'h0000_0003, 32'h0200_0013};
      tbl[4] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
      tbl[5] = '{1'b1, 32'h0000_1000, 32'h0000_0000};
      tbl[6] = '{1'b1, 32'h8000_0004, 32'h0000_0000};
      tbl[7] = '{1'b1, 32'h0000_0007, 32'h0010_0093};
      for (int i = 0; i < 8; i++) begin
         fetch($sformatf("tbl[%0d]", i), tbl[i].ce, tbl[i].addr, tbl[i].exp);
      end

      // loader activity in RUN is ignored
      put(8'hFF, 1, 0, 0); put(8'hFF, 1, 0, 0); put(8'hFF, 1, 0, 0); put(8'hFF, 1, 1, 0);
      chk_state("run ignore");
      fetch("run ignore mem0", 1'b1, 32'h0, 32'h0200_0013);

      // start has priority over a same-cycle byte
      put(8'hEE, 1, 0, 1);
      chk("start busy", bus.busy_o, 1'b1);
      chk("start cnt", bus.load_cnt_o, 11'd0);
      put(8'hAA, 1, 0, 0); put(8'hBB, 1, 0, 0); put(8'hCC, 1, 0, 0); put(8'hDD, 1, 0, 0);
      put(8'h11, 1, 0, 0); put(8'h22, 1, 1, 0);
      chk_state("partial");
      fetch("partial w0", 1'b1, 32'h0, 32'hDDCC_BBAA);
      fetch("partial w1", 1'b1, 32'h4, 32'h0000_2211);

      // reset mid-load discards the partial word but keeps written words
      put(8'h00, 0, 0, 1);
      put(8'h01, 1, 0, 0); put(8'h02, 1, 0, 0); put(8'h03, 1, 0, 0); put(8'h04, 1, 0, 0);
      put(8'h05, 1, 0, 0); put(8'h06, 1, 0, 0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      m_restart();
      chk_state("mid rst");
      put(8'h00, 0, 1, 0);
      chk_state("mid rst done");
      fetch("mid rst w0", 1'b1, 32'h0, 32'h0403_0201);
      fetch("mid rst w1", 1'b1, 32'h4, 32'h0000_2211);

      // randomized loads against the model
      for (int it = 0; it < 8; it++) begin
         put(8'h00, 0, 0, 1);
         chk_state($sformatf("rnd%0d start", it));
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) put(8'h00, 0, 0, 0);
            b = 8'($urandom);
            put(b, 1, (i == n - 1) && ($urandom_range(0, 1) == 1), 0);
         end
         if (m_load) put(8'h00, 0, 1, 0);
         chk_state($sformatf("rnd%0d end", it));
         for (int k = 0; k < 12; k++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
               a = $urandom;
               fetch("rnd ce0", 1'b0, a, m_fetch(1'b0, a));
            end else if (sel == 1) begin
               a = $urandom | 32'h0000_1000;
               fetch("rnd oor", 1'b1, a, m_fetch(1'b1, a));
            end else begin
               a = 32'($urandom_range(0, m_cnt - 1)) * 32'd4 + 32'($urandom_range(0, 3));
               fetch("rnd fetch", 1'b1, a, m_fetch(1'b1, a));
            end
         end
      end

      // small instance: array fills after 16 bytes, the rest are ignored
      for (int i = 0; i < 20; i++) begin
         bus_s.load_valid_i = 1'b1;
         bus_s.load_byte_i  = 8'(8'h10 + i);
         tick();
         if (i == 5) begin
            bus_s.rom_ce_i = 1'b1;
            bus_s.inst_addr_i = 32'h0;
            #1;
            chk("small load fetch", bus_s.inst_o, 32'h0);
            bus_s.rom_ce_i = 1'b0;
         end
         if (i == 15) begin
            chk("small full busy", bus_s.busy_o, 1'b0);
            chk("small full ready", bus_s.load_ready_o, 1'b0);
            chk("small full cnt", bus_s.load_cnt_o, 3'd4);
         end
      end
      bus_s.load_valid_i = 1'b0;
      chk("small cnt hold", bus_s.load_cnt_o, 3'd4);
      for (int k = 0; k < 4; k++) begin
         e = 32'h0;
         for (int j = 0; j < 4; j++) e = e | ((32'h10 + 32'(4 * k + j)) << (8 * j));
         bus_s.rom_ce_i = 1'b1;
         bus_s.inst_addr_i = 32'(4 * k);
         #1;
         chk($sformatf("small w%0d", k), bus_s.inst_o, e);
      end
      bus_s.inst_addr_i = 32'h10;
      #1;
      chk("small oor", bus_s.inst_o, 32'h0);
      bus_s.rom_ce_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
